// File: rtl/seg_display_reader.sv
// Seven-segment display bus reader: recovers the 16-bit hex value shown on a
// time-multiplexed 4-digit active-low display by watching anodes and segments.
module seg_display_reader #(
    parameter int unsigned STABLE_CYCLES = 8,
    parameter int unsigned CNT_W         = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  an_in,
    input  logic [6:0]  seg_in,
    output logic [15:0] value_out,
    output logic [3:0]  digit_err,
    output logic        frame_valid
);

    typedef enum logic {StCollect, StEmit} state_e;

    localparam logic [CNT_W-1:0] StableCnt = CNT_W'(STABLE_CYCLES);

    logic [10:0]      r_sync1, r_sync2, r_last;
    logic [CNT_W-1:0] r_cnt;
    logic [3:0]       r_seen, w_seen_d;
    logic [15:0]      r_shadow, w_shadow_d;
    logic [3:0]       r_err_shadow, w_err_d;
    logic [15:0]      r_value;
    logic [3:0]       r_err;
    state_e           r_state, w_state_next;

    logic       w_same, w_strobe, w_emit;
    logic [3:0] w_an, w_sel;
    logic [6:0] w_seg;
    logic [3:0] w_nibble;
    logic       w_glyph_err;
    logic       w_blank, w_one_hot, w_abort;

    assign w_same    = (r_sync2 == r_last);
    // Fires once, on the cycle the counter reaches its saturation value.
    assign w_strobe  = w_same && (r_cnt == StableCnt - 1'b1);
    assign w_an      = r_last[10:7];
    assign w_seg     = r_last[6:0];
    assign w_sel     = ~w_an;
    assign w_blank   = (w_an == 4'b1111);
    assign w_one_hot = $onehot(w_sel);
    assign w_abort   = !w_blank && !w_one_hot;
    assign w_emit    = (r_state == StCollect) && (r_seen == 4'b1111);

    assign value_out = r_value;
    assign digit_err = r_err;

    // Two-flop synchronizer on the whole bus word, plus one delayed copy for change detect.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= '1;
            r_sync2 <= '1;
            r_last  <= '1;
        end else begin
            r_sync1 <= {an_in, seg_in};
            r_sync2 <= r_sync1;
            r_last  <= r_sync2;
        end
    end

    // Stability counter: cleared on any change, saturates at STABLE_CYCLES.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (!w_same) begin
            r_cnt <= '0;
        end else if (r_cnt != StableCnt) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // Active-low glyph decode, bit 6 = a ... bit 0 = g.
    always_comb begin
        w_nibble    = 4'h0;
        w_glyph_err = 1'b0;
        case (w_seg)
            7'b0000001: w_nibble = 4'h0;
            7'b1001111: w_nibble = 4'h1;
            7'b0010010: w_nibble = 4'h2;
            7'b0000110: w_nibble = 4'h3;
            7'b1001100: w_nibble = 4'h4;
            7'b0100100: w_nibble = 4'h5;
            7'b0100000: w_nibble = 4'h6;
            7'b0001111: w_nibble = 4'h7;
            7'b0000000: w_nibble = 4'h8;
            7'b0001100: w_nibble = 4'h9;
            7'b0001000: w_nibble = 4'hA;
            7'b1100000: w_nibble = 4'hB;
            7'b0110001: w_nibble = 4'hC;
            7'b1000010: w_nibble = 4'hD;
            7'b0110000: w_nibble = 4'hE;
            7'b0111000: w_nibble = 4'hF;
            default:    w_glyph_err = 1'b1;
        endcase
    end

    // Frame assembly; a capture on the emit edge lands in the next frame.
    always_comb begin
        w_seen_d   = r_seen;
        w_shadow_d = r_shadow;
        w_err_d    = r_err_shadow;
        if (w_emit) begin
            w_seen_d = '0;
        end
        if (w_strobe) begin
            if (w_abort) begin
                w_seen_d   = '0;
                w_shadow_d = '0;
                w_err_d    = '0;
            end else if (w_one_hot) begin
                for (int k = 0; k < 4; k++) begin
                    if (w_sel[k]) begin
                        w_shadow_d[4*k +: 4] = w_nibble;
                        w_err_d[k]           = w_glyph_err;
                        w_seen_d[k]          = 1'b1;
                    end
                end
            end
        end
    end

    // Shadow, seen mask and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_seen       <= '0;
            r_shadow     <= '0;
            r_err_shadow <= '0;
            r_value      <= '0;
            r_err        <= '0;
        end else begin
            r_seen       <= w_seen_d;
            r_shadow     <= w_shadow_d;
            r_err_shadow <= w_err_d;
            if (w_emit) begin
                r_value <= r_shadow;
                r_err   <= r_err_shadow;
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StCollect;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next state; frame_valid is high for the single EMIT cycle.
    always_comb begin
        w_state_next = r_state;
        frame_valid  = 1'b0;
        unique case (r_state)
            StCollect: if (r_seen == 4'b1111) w_state_next = StEmit;
            StEmit: begin
                frame_valid  = 1'b1;
                w_state_next = StCollect;
            end
            default: w_state_next = StCollect;
        endcase
    end

endmodule

// File: tb/tb_seg_display_reader.sv
// Scoreboard bench for seg_display_reader: expected frames are queued when the
// final digit is driven and compared when frame_valid pulses.
module tb_seg_display_reader;

    localparam int S = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  an_in;
    logic [6:0]  seg_in;
    logic [15:0] value_out;
    logic [3:0]  digit_err;
    logic        frame_valid;

    typedef struct {
        logic [15:0] value;
        logic [3:0]  err;
        int          cyc;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   cyc      = 0;
    int   n_total  = 0;
    int   n_pass   = 0;
    int   n_pulses = 0;
    int   p0;

    seg_display_reader #(
        .STABLE_CYCLES(S),
        .CNT_W        (4)
    ) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .an_in      (an_in),
        .seg_in     (seg_in),
        .value_out  (value_out),
        .digit_err  (digit_err),
        .frame_valid(frame_valid)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end else begin
            n_pass++;
        end
    endtask

    function automatic logic [6:0] glyph(input logic [3:0] n);
        case (n)
            4'h0: return 7'b0000001;
            4'h1: return 7'b1001111;
            4'h2: return 7'b0010010;
            4'h3: return 7'b0000110;
            4'h4: return 7'b1001100;
            4'h5: return 7'b0100100;
            4'h6: return 7'b0100000;
            4'h7: return 7'b0001111;
            4'h8: return 7'b0000000;
            4'h9: return 7'b0001100;
            4'hA: return 7'b0001000;
            4'hB: return 7'b1100000;
            4'hC: return 7'b0110001;
            4'hD: return 7'b1000010;
            4'hE: return 7'b0110000;
            default: return 7'b0111000;
        endcase
    endfunction

    // Monitor: every pulse must match the oldest queued frame, including its timing.
    always @(negedge clk) begin
        if (frame_valid === 1'b1) begin
            n_pulses++;
            if (sb_q.size() == 0) begin
                check("spurious_pulse", 32'd1, 32'd0);
            end else begin
                mon_e = sb_q.pop_front();
                check("value_out", 32'(value_out), 32'(mon_e.value));
                check("digit_err", 32'(digit_err), 32'(mon_e.err));
                check("latency_cycle", 32'(cyc), 32'(mon_e.cyc));
            end
        end
    end

    // Inputs change on a negedge; the next rising edge is edge T of the latency rule.
    task automatic drive(input logic [3:0] an, input logic [6:0] seg, input int hold);
        an_in  = an;
        seg_in = seg;
        repeat (hold) @(negedge clk);
    endtask

    task automatic send_digit(input int k, input logic [6:0] seg, input int hold);
        logic [3:0] an;
        an = ~(4'b0001 << k);
        drive(an, seg, hold);
    endtask

    task automatic expect_frame(input logic [15:0] v, input logic [3:0] e);
        exp_t x;
        x.value = v;
        x.err   = e;
        x.cyc   = cyc + S + 4;
        sb_q.push_back(x);
    endtask

    task automatic idle(input int n);
        drive(4'b1111, 7'b1111111, n);
    endtask

    task automatic send_frame(input logic [15:0] v, input int hold, input int hold_last);
        for (int k = 0; k < 3; k++) send_digit(k, glyph(v[4*k +: 4]), hold);
        expect_frame(v, 4'b0000);
        send_digit(3, glyph(v[15:12]), hold_last);
    endtask

    task automatic end_test(input string tag, input int pulses, input logic [15:0] v,
                            input logic [3:0] e);
        idle(20);
        check({tag, "_pulses"}, 32'(n_pulses - p0), 32'(pulses));
        check({tag, "_pending"}, 32'(sb_q.size()), 32'd0);
        check({tag, "_hold_value"}, 32'(value_out), 32'(v));
        check({tag, "_hold_err"}, 32'(digit_err), 32'(e));
    endtask

    initial begin
        rst_n  = 1'b0;
        an_in  = 4'b1111;
        seg_in = 7'b1111111;
        repeat (3) @(negedge clk);
        check("reset_value", 32'(value_out), 32'd0);
        check("reset_err", 32'(digit_err), 32'd0);
        check("reset_valid", 32'(frame_valid), 32'd0);
        rst_n = 1'b1;
        idle(10);

        // Clean frame.
        p0 = n_pulses;
        send_frame(16'h1A3F, 20, 20);
        end_test("clean", 1, 16'h1A3F, 4'b0000);

        // Short blank glitch inside digit 1's window.
        p0 = n_pulses;
        send_digit(0, 7'b0111000, 20);
        send_digit(1, 7'b0000110, 7);
        drive(4'b1101, 7'b1111111, 5);
        send_digit(1, 7'b0000110, 20);
        send_digit(2, 7'b0001000, 20);
        expect_frame(16'h1A3F, 4'b0000);
        send_digit(3, 7'b1001111, 20);
        end_test("glitch", 1, 16'h1A3F, 4'b0000);

        // Illegal glyph on digit 2.
        p0 = n_pulses;
        send_digit(0, 7'b0111000, 20);
        send_digit(1, 7'b0000110, 20);
        send_digit(2, 7'b1111111, 20);
        expect_frame(16'h103F, 4'b0100);
        send_digit(3, 7'b1001111, 20);
        end_test("illegal", 1, 16'h103F, 4'b0100);

        // Multi-anode abort; the zero frame is sent as digits 2,3,0,1 so that
        // stale digits 0/1 would complete a frame early if not discarded.
        p0 = n_pulses;
        send_digit(0, 7'b0111000, 20);
        send_digit(1, 7'b0000110, 20);
        drive(4'b1100, glyph(4'h0), 20);
        send_digit(2, glyph(4'h0), 20);
        send_digit(3, glyph(4'h0), 20);
        send_digit(0, glyph(4'h0), 20);
        expect_frame(16'h0000, 4'b0000);
        send_digit(1, glyph(4'h0), 20);
        end_test("abort", 1, 16'h0000, 4'b0000);

        // Continuous scan, then a long freeze on digit 3.
        p0 = n_pulses;
        send_frame(16'h1A3F, 20, 20);
        send_frame(16'h1A3F, 20, 20);
        send_frame(16'h1A3F, 20, 1000);
        end_test("hold", 3, 16'h1A3F, 4'b0000);

        // Reset mid-frame.
        p0 = n_pulses;
        send_digit(0, glyph(4'h5), 20);
        send_digit(1, glyph(4'h6), 20);
        rst_n = 1'b0;
        #1;
        check("midreset_value", 32'(value_out), 32'd0);
        check("midreset_err", 32'(digit_err), 32'd0);
        check("midreset_valid", 32'(frame_valid), 32'd0);
        an_in  = 4'b1111;
        seg_in = 7'b1111111;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        idle(10);
        send_frame(16'hBEEF, 20, 20);
        end_test("reset", 1, 16'hBEEF, 4'b0000);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
